// File: rtl/glb_mc_bus_feeder.sv
// glb_mc_bus_feeder: feeds a tagged word stream from the global buffer onto the multicast bus
// Ports:
//   clk, rstn                      clock; asynchronous active-low reset
//   cfg_start, cfg_len             start pulse and word count (honoured only in IDLE)
//   busy, done                     transfer in progress; one-cycle completion pulse
//   in_data/in_row_id/in_col_id    upstream payload and destination tags
//   in_valid, in_ready             upstream handshake
//   bus_data/bus_row_tag/bus_col_tag  FIFO head driven onto the bus
//   bus_valid, bus_ready           bus handshake
module glb_mc_bus_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_ROW    = 4,
   parameter int NUM_COL    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_WIDTH  = 16,
   parameter int RID_W      = $clog2(NUM_ROW),
   parameter int CID_W      = $clog2(NUM_COL)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cfg_start,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   output logic                  busy,
   output logic                  done,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [RID_W-1:0]      in_row_id,
   input  logic [CID_W-1:0]      in_col_id,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [RID_W-1:0]      bus_row_tag,
   output logic [CID_W-1:0]      bus_col_tag,
   output logic                  bus_valid,
   input  logic                  bus_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + RID_W + CID_W;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic [AW:0] wr_q, rd_q;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] head;
   logic empty, full, push, pop;
   // extra pointer MSB tells a full FIFO apart from an empty one
   assign empty = wr_q == rd_q;
   assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   // ready is a function of registered state only, so full blocks pushes even while popping
   assign in_ready = (state_q == RUN) && !full && (in_cnt_q < len_q);
   assign push = in_valid && in_ready;
   assign bus_valid = !empty;
   assign pop = bus_valid && bus_ready;
   // bus is forced to zero while nothing is buffered (covers reset)
   assign head = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign {bus_data, bus_row_tag, bus_col_tag} = head;
   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = state_q == DONE;
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      in_cnt_d = in_cnt_q + LEN_WIDTH'(push);
      out_cnt_d = out_cnt_q + LEN_WIDTH'(pop);
      case (state_q)
         IDLE: if (cfg_start) begin
            len_d = cfg_len;
            in_cnt_d = '0;
            out_cnt_d = '0;
            state_d = (cfg_len != '0) ? RUN : DONE;
         end
         RUN: state_d = (in_cnt_q == len_q) ? DRAIN : RUN;
         DRAIN: state_d = (out_cnt_q == len_q) ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         len_q <= '0;
         in_cnt_q <= '0;
         out_cnt_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         in_cnt_q <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         wr_q <= wr_q + (AW+1)'(push);
         rd_q <= rd_q + (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= {in_data, in_row_id, in_col_id};
   end
endmodule

// File: tb/tb_glb_mc_bus_feeder.sv
// tb_glb_mc_bus_feeder: directed self-checking bench for glb_mc_bus_feeder
module tb_glb_mc_bus_feeder;
   logic clk = 1'b0;
   logic rstn;
   logic cfg_start;
   logic [15:0] cfg_len;
   logic busy, done;
   logic [15:0] in_data;
   logic [1:0] in_row_id;
   logic [1:0] in_col_id;
   logic in_valid, in_ready;
   logic [15:0] bus_data;
   logic [1:0] bus_row_tag, bus_col_tag;
   logic bus_valid, bus_ready;
   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   glb_mc_bus_feeder dut (
      .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_len(cfg_len),
      .busy(busy), .done(done), .in_data(in_data), .in_row_id(in_row_id),
      .in_col_id(in_col_id), .in_valid(in_valid), .in_ready(in_ready),
      .bus_data(bus_data), .bus_row_tag(bus_row_tag), .bus_col_tag(bus_col_tag),
      .bus_valid(bus_valid), .bus_ready(bus_ready)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // streams words base..base+len-1 (first p0 already pushed) with bus_ready high,
   // checks every beat in order, and expects exactly one done pulse
   task automatic pump(input int len, input int base, input int p0, input int pulse_at);
      int p, exp_d, got, d0;
      bit seen, pushing;
      p = p0; exp_d = base; got = 0; seen = 0; d0 = done_cnt;
      cfg_len = 16'd99;
      for (int c = 0; c < 80; c++) begin
         cfg_start = (c == pulse_at);
         if (bus_valid) begin
            chk("beat_data", {16'h0, bus_data}, exp_d);
            exp_d++;
            got++;
         end
         pushing = in_ready && in_valid;
         tick();
         if (pushing) begin
            p++;
            if (p == len) in_valid = 1'b0;
            else in_data = 16'(base + p);
         end
         if (done) begin
            seen = 1;
            break;
         end
      end
      cfg_start = 1'b0;
      chk("beat_count", got, len);
      chk("done_seen", {31'h0, seen}, 1);
      tick();
      tick();
      chk("done_once", done_cnt - d0, 1);
      chk("idle_busy", {31'h0, busy}, 0);
   endtask

   task automatic xfer(input int len, input int base, input int pulse_at);
      bus_ready = 1'b1;
      cfg_len = 16'(len);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'(base);
      pump(len, base, 0, pulse_at);
   endtask

   logic [1:0] rows [3] = '{2'd0, 2'd3, 2'd2};
   logic [1:0] cols [3] = '{2'd3, 2'd0, 2'd1};

   initial begin
      int d0;
      rstn = 1'b0; cfg_start = 1'b0; cfg_len = '0; in_data = '0; in_row_id = '0;
      in_col_id = '0; in_valid = 1'b0; bus_ready = 1'b0;
      tick();
      tick();
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_in_ready", {31'h0, in_ready}, 0);
      chk("rst_bus_valid", {31'h0, bus_valid}, 0);
      chk("rst_bus_data", {16'h0, bus_data}, 0);
      chk("rst_tags", {28'h0, bus_row_tag, bus_col_tag}, 0);
      rstn = 1'b1;
      tick();

      // T2: 5-word stream at full rate
      d0 = done_cnt;
      bus_ready = 1'b1;
      cfg_len = 16'd5;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("t2_busy", {31'h0, busy}, 1);
      chk("t2_ready0", {31'h0, in_ready}, 1);
      chk("t2_bus_empty", {31'h0, bus_valid}, 0);
      in_valid = 1'b1;
      in_data = 16'd1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("t2_bus_valid", {31'h0, bus_valid}, 1);
         chk("t2_bus_data", {16'h0, bus_data}, k);
         chk("t2_in_ready", {31'h0, in_ready}, (k < 5) ? 1 : 0);
         in_data = 16'(k + 1);
         if (k == 5) in_valid = 1'b0;
      end
      tick();
      chk("t2_drain_valid", {31'h0, bus_valid}, 0);
      chk("t2_drain_busy", {31'h0, busy}, 1);
      chk("t2_drain_done", {31'h0, done}, 0);
      tick();
      chk("t2_done", {31'h0, done}, 1);
      chk("t2_done_busy", {31'h0, busy}, 0);
      tick();
      chk("t2_done_end", {31'h0, done}, 0);
      chk("t2_done_once", done_cnt - d0, 1);

      // T3: backpressure fills the FIFO, then drains in order
      bus_ready = 1'b0;
      cfg_len = 16'd12;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'd101;
      for (int i = 0; i < 8; i++) begin
         tick();
         in_data = 16'(102 + i);
      end
      chk("t3_full_ready", {31'h0, in_ready}, 0);
      chk("t3_hold_valid", {31'h0, bus_valid}, 1);
      chk("t3_hold_data", {16'h0, bus_data}, 101);
      tick();
      tick();
      chk("t3_still_full", {31'h0, in_ready}, 0);
      chk("t3_still_data", {16'h0, bus_data}, 101);
      bus_ready = 1'b1;
      pump(12, 101, 8, -1);

      // T4: tags pass through unmodified
      cfg_len = 16'd3;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'd31; in_row_id = rows[0]; in_col_id = cols[0];
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_row", {30'h0, bus_row_tag}, {30'h0, rows[k]});
         chk("t4_col", {30'h0, bus_col_tag}, {30'h0, cols[k]});
         chk("t4_data", {16'h0, bus_data}, 31 + k);
         if (k < 2) begin
            in_data = 16'(32 + k); in_row_id = rows[k+1]; in_col_id = cols[k+1];
         end else in_valid = 1'b0;
      end
      tick();
      tick();
      chk("t4_done", {31'h0, done}, 1);
      tick();

      // T5: zero-length transfer
      d0 = done_cnt;
      cfg_len = 16'd0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("t5_done", {31'h0, done}, 1);
      chk("t5_busy", {31'h0, busy}, 0);
      chk("t5_ready", {31'h0, in_ready}, 0);
      tick();
      chk("t5_done_end", {31'h0, done}, 0);
      chk("t5_busy_end", {31'h0, busy}, 0);
      chk("t5_ready_end", {31'h0, in_ready}, 0);
      tick();
      chk("t5_done_once", done_cnt - d0, 1);

      // T6: a start pulse during RUN is ignored
      xfer(3, 201, 1);

      // T1: reset mid-transfer with 3 words buffered
      d0 = done_cnt;
      bus_ready = 1'b0;
      cfg_len = 16'd8;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'd71;
      for (int i = 0; i < 3; i++) begin
         tick();
         in_data = 16'(72 + i);
      end
      chk("t1_buffered", {31'h0, bus_valid}, 1);
      rstn = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t1_async_valid", {31'h0, bus_valid}, 0);
      tick();
      chk("t1_bus_valid", {31'h0, bus_valid}, 0);
      chk("t1_in_ready", {31'h0, in_ready}, 0);
      chk("t1_busy", {31'h0, busy}, 0);
      chk("t1_bus_data", {16'h0, bus_data}, 0);
      rstn = 1'b1;
      tick();
      chk("t1_no_done", done_cnt - d0, 0);
      xfer(2, 81, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
